// File: rtl/cola_pkg.sv
// cola_pkg: dispenser state encoding and small helpers.
// Shared with the vending-FSM bench for state decode.
package cola_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t RUN       = 3'd1;
  localparam state_t WAIT_DROP = 3'd2;
  localparam state_t GAP       = 3'd3;
  localparam state_t FAULT     = 3'd4;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/drop_sync_edge.sv
// drop_sync_edge: two-flop synchronizer for the raw drop sensor
// plus a rising-edge pulse taken from the synchronized level.
module drop_sync_edge (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic pi_drop,
  output logic po_rise
);

  logic drop_meta;
  logic drop_sync;
  logic drop_prev;

  // synchronizer chain and edge-detect history
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      drop_meta <= 1'b0;
      drop_sync <= 1'b0;
      drop_prev <= 1'b0;
    end else begin
      drop_meta <= pi_drop;
      drop_sync <= drop_meta;
      drop_prev <= drop_sync;
    end
  end

  assign po_rise = drop_sync & ~drop_prev;

endmodule

// File: rtl/cola_dispenser.sv
// cola_dispenser: queues vend requests, runs the motor per can,
// confirms each drop and latches a fault on a missing can.
module cola_dispenser
  import cola_pkg::*;
#(
  parameter int MOTOR_CYC    = 50,
  parameter int DROP_TIMEOUT = 200,
  parameter int GAP_CYC      = 10,
  parameter int PEND_W       = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pi_cola,
  input  logic              pi_drop,
  input  logic              pi_fault_clr,
  output logic              po_motor,
  output logic              po_busy,
  output logic              po_done,
  output logic              po_fault,
  output logic              po_overflow,
  output logic [PEND_W-1:0] po_pend
);

  localparam int CNT_MAX = max3(MOTOR_CYC, DROP_TIMEOUT, GAP_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MOTOR_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DROP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               drop_seen;
  logic               drop_rise;
  logic               done_nxt;
  logic [PEND_W-1:0]  pend;
  logic [PEND_W-1:0]  pend_nxt;
  logic               pend_dec;
  logic               ovf_nxt;

  drop_sync_edge u_drop (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .pi_drop (pi_drop),
    .po_rise (drop_rise)
  );

  // state register, shared cycle counter and drop latch
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drop_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (state != IDLE && state != FAULT)
        cnt <= cnt + 1'b1;
      if (state_nxt == GAP)
        drop_seen <= 1'b0;
      else if (state == RUN && drop_rise)
        drop_seen <= 1'b1;
    end
  end

  // next-state decode; a drop edge beats a same-cycle timeout
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend != '0)
          state_nxt = RUN;
      end
      RUN: begin
        if (cnt == RUN_LAST) begin
          if (drop_seen || drop_rise) begin
            state_nxt = GAP;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_DROP;
          end
        end
      end
      WAIT_DROP: begin
        if (drop_rise) begin
          state_nxt = GAP;
          done_nxt  = 1'b1;
        end else if (cnt == WAIT_LAST) begin
          state_nxt = FAULT;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST)
          state_nxt = IDLE;
      end
      FAULT: begin
        if (pi_fault_clr)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pending queue: saturating up/down count with overflow flag
  always_comb begin
    pend_dec = (state == IDLE) && (pend != '0);
    pend_nxt = pend;
    ovf_nxt  = 1'b0;
    if (pi_cola && !pend_dec) begin
      if (pend == PEND_MAX)
        ovf_nxt = 1'b1;
      else
        pend_nxt = pend + 1'b1;
    end else if (!pi_cola && pend_dec) begin
      pend_nxt = pend - 1'b1;
    end
  end

  // registered outputs derived from the upcoming state
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      po_motor    <= 1'b0;
      po_busy     <= 1'b0;
      po_done     <= 1'b0;
      po_fault    <= 1'b0;
      po_overflow <= 1'b0;
      pend        <= '0;
    end else begin
      po_motor    <= (state_nxt == RUN);
      po_busy     <= (state_nxt != IDLE);
      po_done     <= done_nxt;
      po_fault    <= (state_nxt == FAULT);
      po_overflow <= ovf_nxt;
      pend        <= pend_nxt;
    end
  end

  assign po_pend = pend;

endmodule

// File: tb/tb_cola_dispenser.sv
// tb_cola_dispenser: directed vectors for the cola dispenser
// with hand-derived expectations at default parameters.
module tb_cola_dispenser;

  logic       sys_clk;
  logic       sys_rst;
  logic       pi_cola;
  logic       pi_drop;
  logic       pi_fault_clr;
  logic       po_motor;
  logic       po_busy;
  logic       po_done;
  logic       po_fault;
  logic       po_overflow;
  logic [2:0] po_pend;

  int total;
  int bad;
  int done_cnt;
  int ovf_cnt;
  int motor_cnt;

  cola_dispenser dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pi_cola      (pi_cola),
    .pi_drop      (pi_drop),
    .pi_fault_clr (pi_fault_clr),
    .po_motor     (po_motor),
    .po_busy      (po_busy),
    .po_done      (po_done),
    .po_fault     (po_fault),
    .po_overflow  (po_overflow),
    .po_pend      (po_pend)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge sys_clk);
    if (po_done) done_cnt++;
    if (po_overflow) ovf_cnt++;
    if (po_motor) motor_cnt++;
  endtask

  task automatic wait_motor(input logic v);
    int n;
    n = 0;
    while (po_motor != v && n < 400) begin
      cyc();
      n++;
    end
    chk("wait_motor", int'(po_motor), int'(v));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (po_busy && n < 100) begin
      cyc();
      n++;
    end
    chk("wait_idle", int'(po_busy), 0);
  endtask

  task automatic serve(input int exp_pend);
    wait_motor(1'b1);
    chk("serve_pend", int'(po_pend), exp_pend);
    repeat (5) cyc();
    pi_drop = 1'b1;
    wait_motor(1'b0);
    chk("serve_done", int'(po_done), 1);
    pi_drop = 1'b0;
  endtask

  initial begin
    int k;
    int d0;
    total        = 0;
    bad          = 0;
    done_cnt     = 0;
    ovf_cnt      = 0;
    motor_cnt    = 0;
    sys_rst      = 1'b1;
    pi_cola      = 1'b0;
    pi_drop      = 1'b0;
    pi_fault_clr = 1'b0;
    cyc();
    cyc();
    chk("rst_motor", int'(po_motor), 0);
    chk("rst_busy", int'(po_busy), 0);
    chk("rst_fault", int'(po_fault), 0);
    chk("rst_pend", int'(po_pend), 0);
    sys_rst = 1'b0;
    cyc();

    // single dispense, drop 20 cycles into RUN
    motor_cnt = 0;
    done_cnt  = 0;
    pi_cola = 1'b1;
    cyc();
    pi_cola = 1'b0;
    chk("t1_pend1", int'(po_pend), 1);
    chk("t1_motor0", int'(po_motor), 0);
    cyc();
    chk("t1_motor1", int'(po_motor), 1);
    chk("t1_pend0", int'(po_pend), 0);
    chk("t1_busy", int'(po_busy), 1);
    pi_fault_clr = 1'b1;
    cyc();
    pi_fault_clr = 1'b0;
    chk("t1_clr_ign", int'(po_motor), 1);
    repeat (18) cyc();
    pi_drop = 1'b1;
    wait_motor(1'b0);
    chk("t1_motor_len", motor_cnt, 50);
    chk("t1_done", int'(po_done), 1);
    chk("t1_gap_busy", int'(po_busy), 1);
    pi_drop = 1'b0;
    repeat (9) cyc();
    chk("t1_done_w", done_cnt, 1);
    chk("t1_gap9", int'(po_busy), 1);
    cyc();
    chk("t1_idle", int'(po_busy), 0);

    // drop edge while idle does nothing
    pi_drop = 1'b1;
    repeat (6) cyc();
    chk("idle_drop_done", done_cnt, 1);
    chk("idle_drop_busy", int'(po_busy), 0);
    pi_drop = 1'b0;
    repeat (4) cyc();

    // late drop, 30 cycles after the motor stops
    pi_cola = 1'b1;
    cyc();
    pi_cola = 1'b0;
    wait_motor(1'b1);
    wait_motor(1'b0);
    chk("t2_nodone", int'(po_done), 0);
    chk("t2_wait_busy", int'(po_busy), 1);
    repeat (29) cyc();
    d0 = done_cnt;
    pi_drop = 1'b1;
    k = 0;
    while (!po_done && k < 20) begin
      cyc();
      k++;
    end
    chk("t2_latency", k, 3);
    chk("t2_fault", int'(po_fault), 0);
    pi_drop = 1'b0;
    wait_idle();
    chk("t2_done_once", done_cnt - d0, 1);

    // timeout into FAULT, queue while faulted, then clear
    motor_cnt = 0;
    d0 = done_cnt;
    pi_cola = 1'b1;
    cyc();
    pi_cola = 1'b0;
    wait_motor(1'b1);
    wait_motor(1'b0);
    chk("t3_motor_len", motor_cnt, 50);
    k = 0;
    while (!po_fault && k < 400) begin
      cyc();
      k++;
    end
    chk("t3_timeout", k, 200);
    chk("t3_motor", int'(po_motor), 0);
    chk("t3_nodone", done_cnt - d0, 0);
    repeat (3) cyc();
    chk("t3_motor_off", motor_cnt, 50);
    pi_cola = 1'b1;
    cyc();
    pi_cola = 1'b0;
    cyc();
    pi_cola = 1'b1;
    cyc();
    pi_cola = 1'b0;
    chk("t3_pend2", int'(po_pend), 2);
    chk("t3_still_fault", int'(po_fault), 1);
    pi_fault_clr = 1'b1;
    cyc();
    pi_fault_clr = 1'b0;
    chk("t3_clr_fault", int'(po_fault), 0);
    chk("t3_clr_idle", int'(po_busy), 0);
    cyc();
    chk("t3_run", int'(po_motor), 1);
    chk("t3_pend1", int'(po_pend), 1);
    serve(1);
    serve(0);
    wait_idle();

    // backlog of nine requests, one overflow
    ovf_cnt = 0;
    d0 = done_cnt;
    pi_cola = 1'b1;
    repeat (9) cyc();
    pi_cola = 1'b0;
    chk("t4_pend7", int'(po_pend), 7);
    chk("t4_ovf", ovf_cnt, 1);
    chk("t4_motor", int'(po_motor), 1);
    for (int i = 0; i < 8; i++)
      serve(7 - i);
    wait_idle();
    chk("t4_served", done_cnt - d0, 8);
    chk("t4_pend0", int'(po_pend), 0);
    chk("t4_ovf_end", ovf_cnt, 1);

    // request coincident with IDLE->RUN at pend=3
    pi_cola = 1'b1;
    cyc();
    pi_cola = 1'b0;
    cyc();
    chk("t5_run", int'(po_motor), 1);
    pi_cola = 1'b1;
    repeat (3) cyc();
    pi_cola = 1'b0;
    chk("t5_pend3", int'(po_pend), 3);
    pi_drop = 1'b1;
    wait_motor(1'b0);
    pi_drop = 1'b0;
    wait_idle();
    pi_cola = 1'b1;
    cyc();
    pi_cola = 1'b0;
    chk("t5_same", int'(po_pend), 3);
    chk("t5_motor", int'(po_motor), 1);

    // reset at motor cycle 25
    motor_cnt = 1;
    repeat (24) cyc();
    chk("t6_cyc25", motor_cnt, 25);
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk("t6_motor", int'(po_motor), 0);
    chk("t6_busy", int'(po_busy), 0);
    chk("t6_done", int'(po_done), 0);
    chk("t6_fault", int'(po_fault), 0);
    chk("t6_ovf", int'(po_overflow), 0);
    chk("t6_pend", int'(po_pend), 0);
    repeat (3) cyc();
    chk("t6_stays_idle", int'(po_busy), 0);
    d0 = done_cnt;
    pi_cola = 1'b1;
    cyc();
    pi_cola = 1'b0;
    serve(0);
    wait_idle();
    chk("t6_redispense", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
